// File: rtl/input_conditioner.sv
// Button/switch input conditioner: two-flop synchronisers followed by
// per-channel debounce state machines with one-cycle event strobes.
module input_conditioner #(
  parameter int DB_COUNT = 20000,
  parameter int CNT_W    = 16,
  parameter int SW_W     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            btn_raw,
  input  logic [SW_W-1:0] sw_raw,
  output logic            btn_level,
  output logic            btn_pulse,
  output logic [SW_W-1:0] sw_stable,
  output logic            sw_changed
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            btn_m_q, btn_s_q;
  logic [SW_W-1:0] sw_m_q, sw_s_q;

  db_state_e       bst_q, bst_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic            btn_level_q, btn_level_d;
  logic            btn_pulse_q, btn_pulse_d;

  db_state_e       sst_q, sst_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [SW_W-1:0] sw_cand_q, sw_cand_d;
  logic [SW_W-1:0] sw_stable_q, sw_stable_d;
  logic            sw_changed_q, sw_changed_d;

  // Synchronisers run every cycle regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m_q <= 1'b0;
      btn_s_q <= 1'b0;
      sw_m_q  <= '0;
      sw_s_q  <= '0;
    end else begin
      btn_m_q <= btn_raw;
      btn_s_q <= btn_m_q;
      sw_m_q  <= sw_raw;
      sw_s_q  <= sw_m_q;
    end
  end

  // Button debounce: a new level must hold DB_COUNT enabled edges.
  always_comb begin
    bst_d       = bst_q;
    bcnt_d      = bcnt_q;
    btn_level_d = btn_level_q;
    btn_pulse_d = 1'b0;
    if (ena) begin
      unique case (bst_q)
        STABLE: begin
          if (btn_s_q != btn_level_q) begin
            bst_d  = PENDING;
            bcnt_d = CNT_ONE;
          end else begin
            bcnt_d = '0;
          end
        end
        PENDING: begin
          if (btn_s_q == btn_level_q) begin
            bst_d  = STABLE;
            bcnt_d = '0;
          end else if (bcnt_q == CNT_LAST) begin
            btn_level_d = btn_s_q;
            btn_pulse_d = btn_s_q;
            bcnt_d      = '0;
            bst_d       = STABLE;
          end else begin
            bcnt_d = bcnt_q + CNT_ONE;
          end
        end
        default: bst_d = STABLE;
      endcase
    end
  end

  // Switch debounce: any further movement restarts the count on the new vector.
  always_comb begin
    sst_d        = sst_q;
    scnt_d       = scnt_q;
    sw_cand_d    = sw_cand_q;
    sw_stable_d  = sw_stable_q;
    sw_changed_d = 1'b0;
    if (ena) begin
      unique case (sst_q)
        STABLE: begin
          if (sw_s_q != sw_stable_q) begin
            sst_d     = PENDING;
            sw_cand_d = sw_s_q;
            scnt_d    = CNT_ONE;
          end else begin
            scnt_d = '0;
          end
        end
        PENDING: begin
          if (sw_s_q == sw_stable_q) begin
            sst_d  = STABLE;
            scnt_d = '0;
          end else if (sw_s_q != sw_cand_q) begin
            sw_cand_d = sw_s_q;
            scnt_d    = CNT_ONE;
          end else if (scnt_q == CNT_LAST) begin
            sw_stable_d  = sw_cand_q;
            sw_changed_d = 1'b1;
            scnt_d       = '0;
            sst_d        = STABLE;
          end else begin
            scnt_d = scnt_q + CNT_ONE;
          end
        end
        default: sst_d = STABLE;
      endcase
    end
  end

  // Debounce state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst_q        <= STABLE;
      bcnt_q       <= '0;
      btn_level_q  <= 1'b0;
      btn_pulse_q  <= 1'b0;
      sst_q        <= STABLE;
      scnt_q       <= '0;
      sw_cand_q    <= '0;
      sw_stable_q  <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      bst_q        <= bst_d;
      bcnt_q       <= bcnt_d;
      btn_level_q  <= btn_level_d;
      btn_pulse_q  <= btn_pulse_d;
      sst_q        <= sst_d;
      scnt_q       <= scnt_d;
      sw_cand_q    <= sw_cand_d;
      sw_stable_q  <= sw_stable_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign btn_level  = btn_level_q;
  assign btn_pulse  = btn_pulse_q;
  assign sw_stable  = sw_stable_q;
  assign sw_changed = sw_changed_q;

endmodule
